// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU stage. Single-cycle ops finish on the accept edge.
// MUL runs an iterative shift-add multiply over WIDTH cycles.
//
// state  | meaning
// S_IDLE | no result held, ready for a new operation
// S_MUL  | shift-add multiply in progress, input port closed
// S_DONE | result and flags held until the consumer takes them
module alu_pipe #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         opcode,
    input  logic [WIDTH-1:0]   data_a,
    input  logic [WIDTH-1:0]   data_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               overflow,
    output logic               is_not_equal,
    output logic               is_less_than,
    output logic               illegal_op
);

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;
    localparam logic [4:0] OP_MUL = 5'b00110;

    localparam logic [SHAMT_W:0] CNT_ONE  = (SHAMT_W+1)'(1);
    localparam logic [SHAMT_W:0] CNT_LAST = (SHAMT_W+1)'(WIDTH-1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t             state_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   result_q;
    logic               overflow_q;
    logic               ne_q;
    logic               lt_q;
    logic               ill_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [SHAMT_W:0]   cnt_q;

    logic [WIDTH-1:0]   res_d;
    logic               ovf_d;
    logic               ill_d;
    logic               ne_d;
    logic               lt_d;
    logic [2*WIDTH-1:0] mul_sum;
    logic               accept;

    // out_ready reaches in_ready combinationally so a held result can be
    // replaced by the next operation in the same cycle it is consumed.
    assign in_ready = !reset &&
                      ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
    assign accept   = in_valid && in_ready;
    assign mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

    assign out_valid    = out_valid_q;
    assign result       = result_q;
    assign overflow     = overflow_q;
    assign is_not_equal = ne_q;
    assign is_less_than = lt_q;
    assign illegal_op   = ill_q;

    // Single-cycle result, overflow and comparison flags for the offered op
    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        ill_d = 1'b0;
        unique case (opcode)
            OP_ADD: begin
                res_d = data_a + data_b;
                ovf_d = (data_a[WIDTH-1] == data_b[WIDTH-1]) &&
                        (res_d[WIDTH-1] != data_a[WIDTH-1]);
            end
            OP_SUB: begin
                res_d = data_a - data_b;
                ovf_d = (data_a[WIDTH-1] != data_b[WIDTH-1]) &&
                        (res_d[WIDTH-1] != data_a[WIDTH-1]);
            end
            OP_AND:  res_d = data_a & data_b;
            OP_OR:   res_d = data_a | data_b;
            OP_SLL:  res_d = data_a << shamt;
            OP_SRA:  res_d = $signed(data_a) >>> shamt;
            OP_MUL:  res_d = '0;
            default: ill_d = 1'b1;
        endcase
        ne_d = !ill_d && (data_a != data_b);
        lt_d = !ill_d && ($signed(data_a) < $signed(data_b));
    end

    // Sequencer: accept, multiply iterations and output hold
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            ne_q        <= 1'b0;
            lt_q        <= 1'b0;
            ill_q       <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                S_MUL: begin
                    acc_q    <= mul_sum;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= mul_sum[WIDTH-1:0];
                        overflow_q  <= |mul_sum[2*WIDTH-1:WIDTH];
                    end
                end
                default: begin
                    if (accept) begin
                        ne_q  <= ne_d;
                        lt_q  <= lt_d;
                        ill_q <= ill_d;
                        if (opcode == OP_MUL) begin
                            state_q     <= S_MUL;
                            out_valid_q <= 1'b0;
                            result_q    <= '0;
                            overflow_q  <= 1'b0;
                            mcand_q     <= {{WIDTH{1'b0}}, data_a};
                            mplier_q    <= data_b;
                            acc_q       <= '0;
                            cnt_q       <= '0;
                        end else begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= res_d;
                            overflow_q  <= ovf_d;
                        end
                    end else if ((state_q == S_DONE) && out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed literal cases plus randomized traffic checked against
// a queue-based behavioural model of the alu_pipe handshake and arithmetic.
module tb_alu_pipe;

    localparam int W = 32;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  opcode = 5'd0;
    logic [31:0] data_a = '0;
    logic [31:0] data_b = '0;
    logic [4:0]  shamt = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        overflow;
    logic        is_not_equal;
    logic        is_less_than;
    logic        illegal_op;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    alu_pipe #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .data_a(data_a), .data_b(data_b), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow),
        .is_not_equal(is_not_equal), .is_less_than(is_less_than),
        .illegal_op(illegal_op)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    typedef struct packed {
        logic [31:0] r;
        logic        ov;
        logic        ne;
        logic        lt;
        logic        il;
    } exp_t;

    typedef struct {
        exp_t e;
        int   avail;
    } entry_t;

    entry_t q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference arithmetic computed with wide integers rather than bit tricks
    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh);
        exp_t e;
        longint sa, sb, s;
        longint unsigned p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e = '0;
        e.ne = (a != b);
        e.lt = (sa < sb);
        case (op)
            5'd0: begin
                s = sa + sb; e.r = s[31:0];
                e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            5'd1: begin
                s = sa - sb; e.r = s[31:0];
                e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            5'd2: e.r = a & b;
            5'd3: e.r = a | b;
            5'd4: begin p = {32'd0, a} << sh; e.r = p[31:0]; end
            5'd5: begin s = sa >>> sh; e.r = s[31:0]; end
            5'd6: begin
                p = longint'(a) * longint'(b);
                e.r = p[31:0];
                e.ov = (p[63:32] != 0);
            end
            default: begin e = '0; e.il = 1'b1; end
        endcase
        return e;
    endfunction

    // Per-cycle compare of handshake and held result against the model
    always @(negedge clock) begin
        logic exp_ov, exp_ir;
        if (reset) begin
            chk("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
            q.delete();
        end else begin
            exp_ov = (q.size() > 0) && (q[0].avail <= cyc);
            exp_ir = (q.size() == 0) || (exp_ov && out_ready);
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
            if (exp_ov && out_valid) begin
                chk("result", result, q[0].e.r);
                chk("flags", {28'd0, overflow, is_not_equal, is_less_than, illegal_op},
                    {28'd0, q[0].e.ov, q[0].e.ne, q[0].e.lt, q[0].e.il});
            end
            if (exp_ov && out_ready) void'(q.pop_front());
            if (in_valid && exp_ir)
                q.push_back('{e: model(opcode, data_a, data_b, shamt),
                              avail: cyc + 1 + ((opcode == 5'd6) ? W : 0)});
        end
    end

    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output exp_t got, output int lat);
        int n;
        @(posedge clock); #1;
        in_valid = 1'b1; opcode = op; data_a = a; data_b = b; shamt = sh;
        out_ready = 1'b1;
        n = 0;
        @(negedge clock);
        while (!in_ready && n < 100) begin @(negedge clock); n++; end
        lat = 0;
        while (1) begin
            @(posedge clock); #1;
            in_valid = 1'b0;
            @(negedge clock);
            lat++;
            if (out_valid || lat >= 100) break;
        end
        got = '{r: result, ov: overflow, ne: is_not_equal, lt: is_less_than, il: illegal_op};
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            5: return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t g;
        int lat, cnt;
        logic [7:0] mask;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_flags", {28'd0, overflow, is_not_equal, is_less_than, illegal_op}, 32'd0);

        do_op(5'd0, 32'h7FFF_FFFF, 32'h1, 5'd0, g, lat);
        chk("add_ovf_result", g.r, 32'h8000_0000);
        chk("add_ovf_flags", {28'd0, g.ov, g.ne, g.lt, g.il}, 32'b1100);
        chk("add_latency", lat, 1);

        do_op(5'd1, 32'h8000_0000, 32'h1, 5'd0, g, lat);
        chk("sub_ovf_result", g.r, 32'h7FFF_FFFF);
        chk("sub_ovf_flags", {28'd0, g.ov, g.ne, g.lt, g.il}, 32'b1110);

        do_op(5'd1, 32'd5, 32'd5, 5'd0, g, lat);
        chk("sub_eq_result", g.r, 32'd0);
        chk("sub_eq_ne", {31'd0, g.ne}, 32'd0);

        do_op(5'd5, 32'h8000_0000, 32'h0, 5'd31, g, lat);
        chk("sra_31", g.r, 32'hFFFF_FFFF);
        do_op(5'd4, 32'h1, 32'h0, 5'd31, g, lat);
        chk("sll_31", g.r, 32'h8000_0000);
        do_op(5'd4, 32'hDEAD_BEEF, 32'h0, 5'd0, g, lat);
        chk("sll_0", g.r, 32'hDEAD_BEEF);
        do_op(5'd5, 32'hDEAD_BEEF, 32'h0, 5'd0, g, lat);
        chk("sra_0", g.r, 32'hDEAD_BEEF);

        do_op(5'd6, 32'h0001_0000, 32'h0001_0000, 5'd0, g, lat);
        chk("mul_big_result", g.r, 32'd0);
        chk("mul_big_ovf", {31'd0, g.ov}, 32'd1);
        chk("mul_latency", lat, 33);
        do_op(5'd6, 32'd7, 32'd6, 5'd0, g, lat);
        chk("mul_7x6", g.r, 32'd42);
        chk("mul_7x6_ovf", {31'd0, g.ov}, 32'd0);
        do_op(5'd6, 32'd0, 32'hFFFF_FFFF, 5'd0, g, lat);
        chk("mul_zero_latency", lat, 33);

        do_op(5'b11111, 32'd3, 32'd9, 5'd2, g, lat);
        chk("illegal_result", g.r, 32'd0);
        chk("illegal_flags", {28'd0, g.ov, g.ne, g.lt, g.il}, 32'b0001);

        // Streaming: four ADDs back to back with the consumer always ready
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock);
        mask = '0;
        for (int i = 0; i < 8; i++) begin
            #1;
            in_valid = (i < 4); opcode = 5'd0; data_a = 32'(i * 3); data_b = 32'd1;
            @(negedge clock);
            mask[i] = out_valid;
            @(posedge clock);
        end
        chk("stream_valid_mask", {24'd0, mask}, 32'h1E);

        // Output stall with a pending producer
        #1;
        out_ready = 1'b1; in_valid = 1'b1; opcode = 5'd0; data_a = 32'd1; data_b = 32'd1;
        @(posedge clock); #1;
        data_a = 32'd2; data_b = 32'd2; out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clock);
            chk("stall_result", result, 32'd2);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock);
        chk("stall_next_result", result, 32'd4);
        repeat (2) @(posedge clock);

        // Reset ten cycles into a MUL
        #1;
        in_valid = 1'b1; opcode = 5'd6; data_a = 32'd123; data_b = 32'd456;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clock);
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("mulrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mulrst_outputs", {27'd0, out_valid, overflow, is_not_equal, is_less_than, illegal_op}, 32'd0);
        chk("mulrst_result", result, 32'd0);
        cnt = 0;
        repeat (40) begin @(negedge clock); if (out_valid) cnt++; end
        chk("mulrst_no_output", cnt, 0);

        // Randomized traffic, checked by the compare process
        for (int i = 0; i < 2500; i++) begin
            @(posedge clock); #1;
            reset     = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            opcode    = ($urandom_range(0, 9) < 7) ? 5'($urandom_range(0, 6))
                                                   : 5'($urandom_range(0, 31));
            data_a    = rnd_val();
            data_b    = rnd_val();
            shamt     = 5'($urandom_range(0, 31));
        end
        @(posedge clock); #1;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (40) @(posedge clock);
        chk("drain_queue_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the single-cycle ALU result selector. Accepts one operation per transfer on a valid/ready input port. Produces a registered result and comparison flags on a valid/ready output port. Single-cycle ops sustain one result per clock; MUL runs as an iterative shift-add multiplier over WIDTH cycles. Sits between operand fetch and writeback in the processor datapath.

## Interface
Parameters:
- WIDTH, 32, operand/result width; power of two, ≥ 4
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept; transfer when in_valid && in_ready
- opcode  in  5  operation select
- data_a  in  WIDTH  operand A
- data_b  in  WIDTH  operand B
- shamt  in  SHAMT_W  shift amount for SLL/SRA
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result; transfer when out_valid && out_ready
- result  out  WIDTH  registered result
- overflow  out  1  see Operation
- is_not_equal  out  1  data_a != data_b
- is_less_than  out  1  signed data_a < data_b
- illegal_op  out  1  accepted opcode not listed below

One clock; reset is synchronous and active-high.

## Operation
- Opcodes:
  - 00000 ADD: a+b
  - 00001 SUB: a−b
  - 00010 AND
  - 00011 OR
  - 00100 SLL: a<<shamt
  - 00101 SRA: arithmetic a>>>shamt
  - 00110 MUL: low WIDTH bits of unsigned a×b
- Any other opcode: result 0, all flags 0 except illegal_op=1. It completes as a single-cycle op.
- overflow:
  - ADD: signed overflow (operand signs equal, result sign differs).
  - SUB: signed overflow (operand signs differ, result sign differs from a).
  - MUL: upper WIDTH bits of the 2·WIDTH-bit product are nonzero.
  - All other ops: 0.
- is_not_equal and is_less_than are computed from the accepted operands for every legal opcode.
- State machine:
  - IDLE → DONE: accept of a non-MUL op.
  - IDLE → MUL: accept of a MUL op.
  - MUL → DONE: when the iteration counter reaches WIDTH−1.
  - DONE → IDLE: on output transfer with no new accept.
  - DONE → DONE or MUL: on output transfer with a simultaneous accept.
- in_ready = (state==IDLE) || (state==DONE && out_ready). The path from out_ready to in_ready is combinational and intended. in_ready is 0 in MUL and while reset is high.
- MUL datapath:
  - Registers: 2·WIDTH-bit multiplicand (initially zero-extended a), WIDTH-bit multiplier (initially b), 2·WIDTH-bit accumulator (initially 0), counter of SHAMT_W+1 bits.
  - Each MUL cycle: if multiplier[0], add multiplicand to accumulator; then shift multiplicand left 1 and multiplier right 1; increment counter.
- In DONE, result and all flags hold stable until the output transfer. Inputs are don't-care outside an accept cycle.

## Timing
- Reset (synchronous): state=IDLE, out_valid=0, result=0, overflow=0, is_not_equal=0, is_less_than=0, illegal_op=0, counter=0.
- Single-cycle op: accepted at edge N; out_valid=1 with result after edge N, i.e. visible in cycle N+1.
- MUL: accepted at edge N; out_valid rises after edge N+WIDTH.
- Back-to-back: with out_ready held 1, single-cycle ops complete one per clock and out_valid stays high.
- Output stall: out_ready=0 holds result, flags and out_valid unchanged indefinitely. in_ready is 0 during the stall.
- in_valid asserted during MUL is ignored; the producer must hold the operation until in_ready.
- Reset mid-MUL or while in DONE: the operation is discarded, no output transfer occurs, and all outputs take their reset values on the next edge.
- Shift boundaries: shamt=0 gives result=a for SLL and SRA. shamt=WIDTH−1 is the maximum.
- MUL by 0 still takes WIDTH cycles.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, overflow=1, is_less_than=0, is_not_equal=1, one cycle after accept.
- SUB 0x80000000 − 0x00000001 → result 0x7FFFFFFF, overflow=1, is_less_than=1. SUB 5−5 → 0, is_not_equal=0.
- SRA 0x80000000 by 31 → 0xFFFFFFFF. SLL 0x00000001 by 31 → 0x80000000. SLL by 0 → a unchanged.
- MUL 0x00010000 × 0x00010000 → result 0, overflow=1, out_valid exactly 33 cycles after accept. MUL 7 × 6 → 42, overflow=0.
- Streaming: 4 ADDs with in_valid=1 and out_ready=1 every cycle → 4 consecutive out_valid cycles. Drop out_ready for 3 cycles mid-stream → result held and in_ready=0 for those cycles.
- Opcode 11111 → illegal_op=1, result 0. Assert reset 10 cycles into a MUL → out_valid never rises, all outputs 0, and in_ready=1 the cycle after reset deasserts.
